// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control block: operation codes, func fields, md_op, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_ctrl_pkg;

    // ALU operation codes (4-bit core; zero-extended to OP_W at the top level)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_PASS = 4'b1111;

    // Main-decoder classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    // R-type function fields
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // md_op encoding (equals func[1:0] of the mult/div group)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/alu_md_seq.sv
// Mult/div sequencer: accepts a request when idle, counts MD_LAT cycles, then pulses hilo_we.
// Latency: md_start same cycle as accept; hilo_we MD_LAT+1 cycles after accept.
// Backpressure: requests are only accepted in IDLE; the top level stalls the requester otherwise.
// Ports: clk, rst (sync, high); md_req/md_func in; md_start, md_op, md_busy, hilo_we out.
module alu_md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       md_req,
    input  logic [1:0] md_func,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       hilo_we
);

    localparam int CNT_W = $clog2(MD_LAT);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       md_op_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            md_op <= MD_MULT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            md_op <= md_op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_op_nxt = md_op;
        md_start  = 1'b0;
        hilo_we   = 1'b0;
        case (state)
            S_IDLE: begin
                if (md_req) begin
                    md_start  = 1'b1;
                    md_op_nxt = md_func;
                    cnt_nxt   = CNT_W'(MD_LAT - 1);
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // cnt runs MD_LAT-1 down to 0, so RUN lasts exactly MD_LAT cycles
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DONE: begin
                hilo_we   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // a start issued during reset would be lost by the datapath
        if (rst) begin
            md_start = 1'b0;
        end
    end

    assign md_busy = (state != S_IDLE);

endmodule

// File: rtl/alu_control_mc.sv
// ALU control with multi-cycle mult/div sequencing and HI/LO hazard stall.
// Latency: operation combinational; mult/div result write MD_LAT+1 cycles after accept.
// Backpressure: stall asserted for mult/div or mfhi/mflo while the unit is busy (incl. DONE).
// Ports: clk, rst, valid_in, ALUOp[1:0], func[5:0] in; operation[OP_W-1:0], md_start, md_op, stall, hilo_we, md_busy out.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int MD_LAT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      func,
    output logic [OP_W-1:0] operation,
    output logic            md_start,
    output logic [1:0]      md_op,
    output logic            stall,
    output logic            hilo_we,
    output logic            md_busy
);

    logic [3:0] op4;
    logic       is_rtype;
    logic       md_req;
    logic       hi_rd;

    always_comb begin
        op4 = OP_AND;
        case (ALUOp)
            ALUOP_ADD: op4 = OP_ADD;
            ALUOP_SUB: op4 = OP_SUB;
            ALUOP_ORI: op4 = OP_OR;
            default: begin
                case (func)
                    FN_ADD, FN_ADDU:              op4 = OP_ADD;
                    FN_SUB, FN_SUBU:              op4 = OP_SUB;
                    FN_AND:                       op4 = OP_AND;
                    FN_OR:                        op4 = OP_OR;
                    FN_XOR:                       op4 = OP_XOR;
                    FN_NOR:                       op4 = OP_NOR;
                    FN_SLT:                       op4 = OP_SLT;
                    FN_SLL:                       op4 = OP_SLL;
                    FN_SRL:                       op4 = OP_SRL;
                    FN_SRA:                       op4 = OP_SRA;
                    FN_MFHI, FN_MFLO,
                    FN_MULT, FN_MULTU,
                    FN_DIV, FN_DIVU:              op4 = OP_PASS;
                    default:                      op4 = OP_AND;
                endcase
            end
        endcase
    end

    assign operation = OP_W'(op4);

    assign is_rtype = valid_in && (ALUOp == ALUOP_RTYPE);
    // 0x18..0x1B share func[5:2] = 4'b0110
    assign md_req   = is_rtype && (func[5:2] == 4'b0110);
    assign hi_rd    = is_rtype && ((func == FN_MFHI) || (func == FN_MFLO));
    assign stall    = (md_req || hi_rd) && md_busy;

    alu_md_seq #(
        .MD_LAT (MD_LAT)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .md_req   (md_req),
        .md_func  (func[1:0]),
        .md_start (md_start),
        .md_op    (md_op),
        .md_busy  (md_busy),
        .hilo_we  (hilo_we)
    );

endmodule

// File: tb/tb_alu_control_mc.sv
module tb_alu_control_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [1:0] ALUOp;
    logic [5:0] func;
    logic [3:0] operation;
    logic       md_start;
    logic [1:0] md_op;
    logic       stall;
    logic       hilo_we;
    logic       md_busy;

    int tests = 0;
    int fails = 0;

    alu_control_mc #(
        .OP_W   (4),
        .MD_LAT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ALUOp     (ALUOp),
        .func      (func),
        .operation (operation),
        .md_start  (md_start),
        .md_op     (md_op),
        .stall     (stall),
        .hilo_we   (hilo_we),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] fn;
        logic [3:0] exp_op;
    } dec_vec_t;

    dec_vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs driven after this apply to the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f);
        valid_in = v;
        ALUOp    = a;
        func     = f;
        #1;
    endtask

    task automatic idle_bus();
        drive(1'b0, 2'b00, 6'h00);
    endtask

    initial begin
        vecs[0]  = '{2'b10, 6'h26, 4'b0011};
        vecs[1]  = '{2'b10, 6'h27, 4'b1100};
        vecs[2]  = '{2'b10, 6'h3F, 4'b0000};
        vecs[3]  = '{2'b11, 6'h22, 4'b0001};
        vecs[4]  = '{2'b11, 6'h3F, 4'b0001};
        vecs[5]  = '{2'b00, 6'h22, 4'b0010};
        vecs[6]  = '{2'b01, 6'h20, 4'b0110};
        vecs[7]  = '{2'b10, 6'h20, 4'b0010};
        vecs[8]  = '{2'b10, 6'h21, 4'b0010};
        vecs[9]  = '{2'b10, 6'h22, 4'b0110};
        vecs[10] = '{2'b10, 6'h23, 4'b0110};
        vecs[11] = '{2'b10, 6'h24, 4'b0000};
        vecs[12] = '{2'b10, 6'h25, 4'b0001};
        vecs[13] = '{2'b10, 6'h2A, 4'b0111};
        vecs[14] = '{2'b10, 6'h00, 4'b1000};
        vecs[15] = '{2'b10, 6'h02, 4'b1001};
        vecs[16] = '{2'b10, 6'h03, 4'b1010};
        vecs[17] = '{2'b10, 6'h10, 4'b1111};
        vecs[18] = '{2'b10, 6'h12, 4'b1111};
        vecs[19] = '{2'b10, 6'h1B, 4'b1111};
        vecs[20] = '{2'b10, 6'h01, 4'b0000};
        vecs[21] = '{2'b10, 6'h11, 4'b0000};

        rst = 1'b1;
        idle_bus();
        tick();
        tick();
        // start is gated while in reset even with a mult request present
        drive(1'b1, 2'b10, 6'h18);
        check("rst_md_start", md_start, 1'b0);
        tick();
        check("rst_busy", md_busy, 1'b0);
        check("rst_hilo_we", hilo_we, 1'b0);
        check("rst_md_op", md_op, 2'b00);
        idle_bus();
        rst = 1'b0;
        tick();
        check("rst_stall", stall, 1'b0);

        // combinational decode table (valid_in low so nothing is started)
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].aluop, vecs[i].fn);
            check($sformatf("dec[%0d]", i), operation, vecs[i].exp_op);
            check($sformatf("dec_start[%0d]", i), md_start, 1'b0);
        end
        idle_bus();
        tick();

        // multu accepted at T: busy T+1..T+5, hilo_we only at T+5
        drive(1'b1, 2'b10, 6'h19);
        check("multu_start", md_start, 1'b1);
        check("multu_busy_T", md_busy, 1'b0);
        check("multu_stall_T", stall, 1'b0);
        tick();
        idle_bus();
        check("multu_op", md_op, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("multu_busy_T+%0d", k), md_busy, (k <= 5));
            check($sformatf("multu_hwe_T+%0d", k), hilo_we, (k == 5));
            check($sformatf("multu_start_T+%0d", k), md_start, 1'b0);
            tick();
        end

        // div at T, mfhi from T+2: stall T+2..T+5, released at T+6
        drive(1'b1, 2'b10, 6'h1A);
        check("div_start", md_start, 1'b1);
        tick();
        idle_bus();
        tick();
        drive(1'b1, 2'b10, 6'h10);
        check("div_op", md_op, 2'b10);
        for (int k = 2; k <= 6; k++) begin
            check($sformatf("mfhi_stall_T+%0d", k), stall, (k <= 5));
            check($sformatf("mfhi_oper_T+%0d", k), operation, 4'b1111);
            check($sformatf("mfhi_hwe_T+%0d", k), hilo_we, (k == 5));
            tick();
        end
        idle_bus();
        tick();

        // independent add and R-type ops during RUN never stall
        drive(1'b1, 2'b10, 6'h18);
        check("mult_start", md_start, 1'b1);
        tick();
        idle_bus();
        tick();
        drive(1'b1, 2'b00, 6'h1A);
        check("add_run_busy", md_busy, 1'b1);
        check("add_run_stall", stall, 1'b0);
        check("add_run_oper", operation, 4'b0010);
        tick();
        drive(1'b1, 2'b10, 6'h25);
        check("or_run_stall", stall, 1'b0);
        check("or_run_oper", operation, 4'b0001);
        tick();
        idle_bus();
        for (int k = 0; k < 4; k++) tick();
        check("add_seq_idle", md_busy, 1'b0);

        // divu at T, reset at T+2: aborted, md_op cleared, no hilo_we pulse
        drive(1'b1, 2'b10, 6'h1B);
        check("divu_start", md_start, 1'b1);
        tick();
        idle_bus();
        check("divu_op", md_op, 2'b11);
        tick();
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'h18);
        check("rst_run_start", md_start, 1'b0);
        tick();
        rst = 1'b0;
        idle_bus();
        check("abort_busy", md_busy, 1'b0);
        check("abort_md_op", md_op, 2'b00);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("abort_hwe_%0d", k), hilo_we, 1'b0);
            tick();
        end

        // second mult arriving in DONE stalls once, then starts a fresh count
        drive(1'b1, 2'b10, 6'h19);
        check("bb_start1", md_start, 1'b1);
        tick();
        idle_bus();
        for (int k = 1; k < 5; k++) tick();
        drive(1'b1, 2'b10, 6'h18);
        check("bb_done_hwe", hilo_we, 1'b1);
        check("bb_done_stall", stall, 1'b1);
        check("bb_done_start", md_start, 1'b0);
        tick();
        check("bb_idle_stall", stall, 1'b0);
        check("bb_start2", md_start, 1'b1);
        check("bb_idle_busy", md_busy, 1'b0);
        tick();
        idle_bus();
        check("bb_op2", md_op, 2'b00);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("bb2_busy_%0d", k), md_busy, (k <= 5));
            check($sformatf("bb2_hwe_%0d", k), hilo_we, (k == 5));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_control_mc.md
ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 SHALL have parameter OP_W, default 4, meaning width of the ALU operation code (minimum 4).
REQ-002 SHALL have parameter MD_LAT, default 32, meaning mult/div execution cycles (minimum 2); CNT_W = clog2(MD_LAT).
REQ-003 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  in  1  the EX-stage instruction is valid.
REQ-006 SHALL have port ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 R-type, 11 or-immediate.
REQ-007 SHALL have port func  in  6  R-type function field.
REQ-008 SHALL have port operation  out  OP_W  ALU operation code (combinational).
REQ-009 SHALL have port md_start  out  1  one-cycle start pulse to the mult/div datapath.
REQ-010 SHALL have port md_op  out  2  captured op: 00 mult, 01 multu, 10 div, 11 divu.
REQ-011 SHALL have port stall  out  1  freeze the pipeline front end this cycle.
REQ-012 SHALL have port hilo_we  out  1  HI/LO write-enable pulse.
REQ-013 SHALL have port md_busy  out  1  mult/div unit occupied.

Function
REQ-014 operation codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, NOR 1100, PASS 1111; upper bits are zero when OP_W>4.
REQ-015 ALUOp 00 -> ADD; 01 -> SUB; 11 -> OR, with func ignored.
REQ-016 ALUOp 10 SHALL decode all six func bits: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x10/0x12/0x18-0x1B PASS; any other value -> AND.
REQ-017 Signals md_req = valid_in & ALUOp==10 & func in 0x18..0x1B, and hi_rd = valid_in & ALUOp==10 & func in {0x10,0x12}.
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE; md_busy = (state != IDLE).
REQ-019 stall = (md_req | hi_rd) & md_busy; operation SHALL still be driven while stall is asserted.
REQ-020 Accept = md_req & ~md_busy; on accept, md_start=1 (combinational, same cycle), md_op <= func[1:0], cnt <= MD_LAT-1, state <= RUN.
REQ-021 In RUN, cnt decrements every cycle; when cnt==0, state <= DONE.
REQ-022 In DONE, hilo_we=1 for exactly one cycle; state <= IDLE next cycle.
REQ-023 Latency: accept at cycle T -> RUN during T+1..T+MD_LAT -> hilo_we at T+MD_LAT+1 -> a dependent mfhi/mflo proceeds at T+MD_LAT+2.
REQ-024 A mult/div or mfhi/mflo arriving in the DONE cycle SHALL stall; no back-to-back overlap is permitted.
REQ-025 md_op SHALL hold its value from accept until the next accept.
REQ-026 Non-md R-type and non-R instructions SHALL never stall, even while md_busy.

Reset
REQ-027 rst SHALL force, at the next edge: state IDLE, cnt 0, md_op 00, hilo_we 0, md_busy 0.
REQ-028 Reset mid-RUN or in DONE SHALL abort the operation with no hilo_we pulse; rst has priority over accept.
REQ-029 While rst is high, md_start SHALL be 0.

Structure
REQ-030 Package alu_ctrl_pkg SHALL hold the operation code constants, func constants, md_op encoding and the state enum.
REQ-031 The FSM and counter SHALL be the sub-module alu_md_seq; decode stays in the top level.

Verification
REQ-032 ALUOp=10, func 0x26 and 0x27 -> operation 0011 and 1100; func 0x3F -> 0000; ALUOp=11, any func -> 0001.
REQ-033 MD_LAT=4, multu accepted at T -> md_start at T, md_op=01, md_busy T+1..T+5, hilo_we only at T+5.
REQ-034 mfhi issued at T+2 after a div accepted at T (MD_LAT=4) -> stall high T+2..T+5, low at T+6.
REQ-035 add issued during RUN -> stall 0, operation 0010.
REQ-036 rst asserted at T+2 of a mult -> at T+3: md_busy 0, md_op 00; hilo_we is never asserted.
REQ-037 Second mult arrives in the DONE cycle -> stalled one cycle, then accepted with md_start=1 and a fresh count.
